// File: rtl/wordgen_pkg.sv
// rtl/wordgen_pkg.sv - shared FSM state, line levels and frame length for wordgen_seq (option: WORDGEN_PARITY_EN)
package wordgen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    NEXT,
    GAP
  } state_t;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

`ifdef WORDGEN_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Bits per frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int word_w);
    return word_w + 2 + PARITY_BITS;
  endfunction

endpackage

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - one-frame async serializer with registered line output (option: WORDGEN_PARITY_EN)
module serial_tx
  import wordgen_pkg::*;
#(
  parameter int WORD_W     = 8,
  parameter int BIT_CYCLES = 434
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] data,
  output logic              out,
  output logic              last_cycle
);

  localparam int FRAME_BITS = frame_bits(WORD_W);
  localparam int BCNT_W     = $clog2(BIT_CYCLES);
  localparam int POS_W      = $clog2(FRAME_BITS);

  localparam logic [BCNT_W-1:0] BCNT_MAX      = BCNT_W'(BIT_CYCLES - 1);
  localparam logic [POS_W-1:0]  POS_LAST      = POS_W'(FRAME_BITS - 1);
  localparam logic [POS_W-1:0]  POS_DATA_LAST = POS_W'(WORD_W);

  logic              active;
  logic [BCNT_W-1:0] bit_cnt;
  logic [POS_W-1:0]  bit_pos;
  logic [POS_W-1:0]  pos_nxt;
  logic [WORD_W-1:0] shreg;
  logic              bit_end;
  logic              lvl_nxt;

  assign bit_end    = active && (bit_cnt == BCNT_MAX);
  assign last_cycle = bit_end && (bit_pos == POS_LAST);
  assign pos_nxt    = bit_pos + POS_W'(1);

`ifdef WORDGEN_PARITY_EN
  localparam logic [POS_W-1:0] POS_PARITY = POS_W'(WORD_W + 1);

  logic parity;

  always_ff @(posedge sysclk) begin
    if (rst) begin
      parity <= 1'b0;
    end else if (load) begin
      parity <= ^data;
    end
  end

  always_comb begin
    lvl_nxt = STOP_LVL;
    if (pos_nxt <= POS_DATA_LAST) begin
      lvl_nxt = shreg[0];
    end else if (pos_nxt == POS_PARITY) begin
      lvl_nxt = parity;
    end
  end
`else
  always_comb begin
    lvl_nxt = STOP_LVL;
    if (pos_nxt <= POS_DATA_LAST) begin
      lvl_nxt = shreg[0];
    end
  end
`endif

  // The line level for the upcoming bit is registered at the bit boundary.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      active  <= 1'b0;
      bit_cnt <= '0;
      bit_pos <= '0;
      shreg   <= '0;
      out     <= IDLE_LVL;
    end else if (load) begin
      active  <= 1'b1;
      bit_cnt <= '0;
      bit_pos <= '0;
      shreg   <= data;
      out     <= START_LVL;
    end else if (active) begin
      if (bit_end) begin
        bit_cnt <= '0;
        if (bit_pos == POS_LAST) begin
          active <= 1'b0;
          out    <= IDLE_LVL;
        end else begin
          bit_pos <= pos_nxt;
          out     <= lvl_nxt;
          if (pos_nxt <= POS_DATA_LAST) begin
            shreg <= shreg >> 1;
          end
        end
      end else begin
        bit_cnt <= bit_cnt + BCNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/wordgen_seq.sv
// rtl/wordgen_seq.sv - word-table sequencer driving serial_tx, single-shot and auto-repeat (option: WORDGEN_PARITY_EN)
module wordgen_seq
  import wordgen_pkg::*;
#(
  parameter int WORD_W     = 8,
  parameter int N_WORDS    = 4,
  parameter int BIT_CYCLES = 434,
  parameter int GAP_CYCLES = 50000000
) (
  input  logic                                         sysclk,
  input  logic                                         rst,
  input  logic [N_WORDS*WORD_W-1:0]                    words,
  input  logic [$clog2(N_WORDS+1)-1:0]                 count,
  input  logic                                         start,
  input  logic                                         auto_toggle,
  output logic                                         out,
  output logic                                         busy,
  output logic                                         auto_on,
  output logic [(N_WORDS > 1 ? $clog2(N_WORDS) : 1)-1:0] word_idx,
  output logic                                         seq_done
);

  localparam int CNT_W = $clog2(N_WORDS + 1);
  localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] N_WORDS_C = CNT_W'(N_WORDS);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  state_t            state, state_nxt;
  logic [WORD_W-1:0] table_q [N_WORDS];
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  last_idx;
  logic [IDX_W-1:0]  count_last;
  logic [GAP_W-1:0]  gap_cnt;
  logic              load;
  logic              tx_last;
  logic              seq_begin;

  // Zero or an oversized count means the whole table.
  always_comb begin
    count_last = IDX_W'(N_WORDS - 1);
    if (count != '0 && count <= N_WORDS_C) begin
      count_last = IDX_W'(count - CNT_W'(1));
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    busy      = 1'b0;
    seq_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start || auto_on) state_nxt = LOAD;
      end
      LOAD: begin
        busy      = 1'b1;
        load      = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        busy = 1'b1;
        if (tx_last) state_nxt = NEXT;
      end
      NEXT: begin
        if (idx < last_idx) begin
          busy      = 1'b1;
          state_nxt = LOAD;
        end else begin
          seq_done  = 1'b1;
          state_nxt = auto_on ? GAP : IDLE;
        end
      end
      GAP: begin
        if (!auto_on || gap_cnt == GAP_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign seq_begin = (state == IDLE) && (state_nxt == LOAD);

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      last_idx <= '0;
      gap_cnt  <= '0;
      auto_on  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (auto_toggle) auto_on <= !auto_on;
      if (seq_begin) begin
        idx      <= '0;
        last_idx <= count_last;
      end else if (state == NEXT && state_nxt == LOAD) begin
        idx <= idx + IDX_W'(1);
      end
      gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
    end
  end

  // Table snapshot is pure data; it is always rewritten before use.
  always_ff @(posedge sysclk) begin
    if (seq_begin) begin
      for (int i = 0; i < N_WORDS; i++) begin
        table_q[i] <= words[i*WORD_W +: WORD_W];
      end
    end
  end

  assign word_idx = idx;

  serial_tx #(
    .WORD_W    (WORD_W),
    .BIT_CYCLES(BIT_CYCLES)
  ) u_tx (
    .sysclk    (sysclk),
    .rst       (rst),
    .load      (load),
    .data      (table_q[idx]),
    .out       (out),
    .last_cycle(tx_last)
  );

endmodule

// File: tb/tb_wordgen_seq.sv
// tb/tb_wordgen_seq.sv - self-checking bench for wordgen_seq (option: WORDGEN_PARITY_EN)
module tb_wordgen_seq;

  localparam int WORD_W     = 8;
  localparam int N_WORDS    = 4;
  localparam int BIT_CYCLES = 4;
  localparam int GAP_CYCLES = 10;
`ifdef WORDGEN_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = (WORD_W + 2 + PAR) * BIT_CYCLES;

  logic        sysclk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] words = '0;
  logic [2:0]  count = '0;
  logic        start = 1'b0;
  logic        auto_toggle = 1'b0;
  logic        out, busy, auto_on, seq_done;
  logic [1:0]  word_idx;

  int asserts = 0;
  int fails = 0;

  int e_out[$], e_busy[$], e_done[$], e_idx[$];
  int cap[$];

  typedef struct {
    logic [31:0] w;
    int          cnt;
    int          frames;
  } vec_t;
  vec_t tbl[5];

  always #5 sysclk = ~sysclk;

  wordgen_seq #(
    .WORD_W(WORD_W), .N_WORDS(N_WORDS), .BIT_CYCLES(BIT_CYCLES), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .sysclk(sysclk), .rst(rst), .words(words), .count(count), .start(start),
    .auto_toggle(auto_toggle), .out(out), .busy(busy), .auto_on(auto_on),
    .word_idx(word_idx), .seq_done(seq_done)
  );

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    asserts++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int clamp(input int c);
    return (c == 0 || c > N_WORDS) ? N_WORDS : c;
  endfunction

  task automatic push(input int o, input int b, input int d, input int i);
    e_out.push_back(o);
    e_busy.push_back(b);
    e_done.push_back(d);
    e_idx.push_back(i);
  endtask

  // Expected line, busy, done and index per cycle, starting at the cycle after start is sampled.
  task automatic build_model(input logic [31:0] w, input int cnt);
    int n;
    int lvl;
    logic [7:0] wd;
    n = clamp(cnt);
    e_out.delete(); e_busy.delete(); e_done.delete(); e_idx.delete();
    push(1, 1, 0, 0);
    for (int k = 0; k < n; k++) begin
      wd = w[k*8 +: 8];
      for (int b = 0; b < WORD_W + 2 + PAR; b++) begin
        if (b == 0) lvl = 0;
        else if (b <= WORD_W) lvl = int'(wd[b-1]);
        else if (PAR == 1 && b == WORD_W + 1) lvl = int'(^wd);
        else lvl = 1;
        repeat (BIT_CYCLES) push(lvl, 1, 0, k);
      end
      if (k < n - 1) begin
        push(1, 1, 0, -1);
        push(1, 1, 0, -1);
      end
    end
    push(1, 0, 1, -1);
    repeat (12) push(1, 0, 0, -1);
  endtask

  task automatic run_seq(input string nm, input logic [31:0] w, input int cnt,
                         input bit mid_start, input bit chg, input logic [31:0] w2,
                         input int exp_busy);
    int bad_out, bad_busy, bad_done, bad_idx, busy_n;
    build_model(w, cnt);
    cap.delete();
    words = w;
    count = 3'(cnt);
    start = 1'b1;
    tick();
    start = 1'b0;
    bad_out = -1; bad_busy = -1; bad_done = -1; bad_idx = -1; busy_n = 0;
    for (int i = 0; i < e_out.size(); i++) begin
      cap.push_back(int'(out));
      if (out !== e_out[i][0] && bad_out < 0) bad_out = i;
      if (busy !== e_busy[i][0] && bad_busy < 0) bad_busy = i;
      if (seq_done !== e_done[i][0] && bad_done < 0) bad_done = i;
      if (e_idx[i] >= 0 && int'(word_idx) != e_idx[i] && bad_idx < 0) bad_idx = i;
      if (busy === 1'b1) busy_n++;
      start = mid_start && (i == 20);
      if (chg && i == 15) words = w2;
      tick();
    end
    start = 1'b0;
    chk({nm, " out first bad cycle"}, bad_out, -1);
    chk({nm, " busy first bad cycle"}, bad_busy, -1);
    chk({nm, " seq_done first bad cycle"}, bad_done, -1);
    chk({nm, " word_idx first bad cycle"}, bad_idx, -1);
    chk({nm, " word_idx hold"}, int'(word_idx), clamp(cnt) - 1);
    if (exp_busy >= 0) chk({nm, " busy cycles"}, busy_n, exp_busy);
  endtask

  initial begin
    int rises[$];
    int dones_after;
    int toggled;
    int seen;
    bit pb;

    tbl[0] = '{32'h44332211, 2, 2};
    tbl[1] = '{32'hA5C30F81, 0, 4};
    tbl[2] = '{32'hFFFFFF00, 1, 1};
    tbl[3] = '{32'h12345678, 4, 4};
    tbl[4] = '{32'h00000055, 7, 4};

    repeat (3) tick();
    chk("reset out", int'(out), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset auto_on", int'(auto_on), 0);
    chk("reset word_idx", int'(word_idx), 0);
    chk("reset seq_done", int'(seq_done), 0);
    rst = 1'b0;
    repeat (2) tick();

    for (int t = 0; t < 5; t++) begin
      run_seq($sformatf("vec%0d", t), tbl[t].w, tbl[t].cnt, 1'b0, 1'b0, 32'h0,
              tbl[t].frames * (FRAME + 2) - 1);
    end

    run_seq("mid_start", 32'h0F1E2D3C, 0, 1'b1, 1'b0, 32'h0, 4 * (FRAME + 2) - 1);

    run_seq("latched", 32'hC0DEBEEF, 3, 1'b0, 1'b1, 32'h5A5A1234, -1);
    run_seq("new_table", 32'h5A5A1234, 3, 1'b0, 1'b0, 32'h0, -1);

    // Reset mid-frame while auto mode is on.
    words = 32'h000000A5;
    count = 3'd1;
    auto_toggle = 1'b1;
    tick();
    auto_toggle = 1'b0;
    repeat (12) tick();
    chk("pre-rst busy", int'(busy), 1);
    chk("pre-rst auto_on", int'(auto_on), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst mid-frame out", int'(out), 1);
    chk("rst mid-frame busy", int'(busy), 0);
    chk("rst mid-frame auto_on", int'(auto_on), 0);
    repeat (3) tick();
    run_seq("post_rst", 32'h000000A5, 1, 1'b0, 1'b0, 32'h0, FRAME + 1);

    // Auto repeat, then switched off mid-frame of the third sequence.
    words = 32'h00000011;
    count = 3'd1;
    auto_toggle = 1'b1;
    tick();
    auto_toggle = 1'b0;
    pb = 1'b0;
    dones_after = 0;
    toggled = 0;
    for (int i = 0; i < 260; i++) begin
      if (busy === 1'b1 && !pb) rises.push_back(i);
      pb = busy;
      if (toggled == 1 && seq_done === 1'b1) dones_after++;
      auto_toggle = (rises.size() == 3) && (i == rises[2] + 10);
      if (auto_toggle) toggled = 1;
      tick();
    end
    auto_toggle = 1'b0;
    chk("auto sequences", rises.size(), 3);
    if (rises.size() >= 3) begin
      chk("auto period 1", rises[1] - rises[0], FRAME + GAP_CYCLES + 3);
      chk("auto period 2", rises[2] - rises[1], FRAME + GAP_CYCLES + 3);
    end
    chk("auto-off done pulses", dones_after, 1);
    chk("auto-off auto_on", int'(auto_on), 0);
    chk("auto-off busy", int'(busy), 0);

    // Clearing auto mode during GAP aborts it.
    auto_toggle = 1'b1;
    tick();
    auto_toggle = 1'b0;
    seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      if (seq_done === 1'b1) seen = 1;
      tick();
    end
    chk("gap abort saw done", seen, 1);
    auto_toggle = 1'b1;
    tick();
    auto_toggle = 1'b0;
    rises.delete();
    pb = busy;
    for (int i = 0; i < 60; i++) begin
      if (busy === 1'b1 && !pb) rises.push_back(i);
      pb = busy;
      tick();
    end
    chk("gap abort no restart", rises.size(), 0);
    chk("gap abort auto_on", int'(auto_on), 0);

    for (int r = 0; r < 6; r++) begin
      run_seq($sformatf("rand%0d", r), 32'($urandom), int'($urandom_range(0, 7)),
              1'b0, 1'b0, 32'h0, -1);
    end

`ifdef WORDGEN_PARITY_EN
    run_seq("parity", 32'h00000307, 2, 1'b0, 1'b0, 32'h0, 2 * (FRAME + 2) - 1);
    chk("parity bit of 07", cap[37], 1);
    chk("parity bit of 03", cap[83], 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/wordgen_seq.md
Name: wordgen_seq

Overview:
Parametrised word-sequence generator. It snapshots a table of N_WORDS words and transmits the first `count` of them on a single async-serial line: idle high, start bit 0, WORD_W data bits LSB first, stop bit 1.
- Single-shot mode: one sequence per start pulse.
- Auto mode: sequences repeat with a programmable idle gap.
- Sits between the debounced button/switch front end and the board serial pin. Inputs arrive already debounced and one-cycle pulsed.

Parameters:
- WORD_W, 8, data bits per frame (1..16)
- N_WORDS, 4, table depth (>=1)
- BIT_CYCLES, 434, sysclk cycles per serial bit (>=2)
- GAP_CYCLES, 50000000, idle cycles between sequences in auto mode (>=1)

Ports:
- sysclk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- words  in  N_WORDS*WORD_W  word table; word i = bits [i*WORD_W +: WORD_W]
- count  in  $clog2(N_WORDS+1)  words per sequence; 0 or >N_WORDS means N_WORDS
- start  in  1  one-cycle request for a single sequence
- auto_toggle  in  1  one-cycle pulse toggling auto mode
- out  out  1  serial line
- busy  out  1  high from LOAD of first word until sequence end
- auto_on  out  1  current auto-mode state
- word_idx  out  $clog2(N_WORDS) (min 1)  index of the word being sent
- seq_done  out  1  one-cycle pulse after last stop bit of each sequence

Behaviour:
- Reset (rst sampled high on a sysclk edge):
  - out=1, busy=0, auto_on=0, word_idx=0, seq_done=0, FSM to IDLE.
  - Takes effect the next cycle even mid-frame; no partial frame is completed.
- FSM states: IDLE, LOAD, SEND, NEXT, GAP.
- IDLE:
  - If start=1 or auto_on=1 at the edge: latch words and clamped count into internal registers, set idx=0, go to LOAD.
  - Table changes after the latch have no effect until the next sequence.
- LOAD (1 cycle):
  - busy=1; load word[idx] into the serializer; go to SEND.
- SEND:
  - Serializer drives start bit, then data LSB first, then stop bit, each exactly BIT_CYCLES cycles. Frame = (WORD_W+2)*BIT_CYCLES cycles.
  - The first start-bit cycle is 2 cycles after start is sampled.
  - On the final stop-bit cycle go to NEXT.
- NEXT (1 cycle, out=1):
  - If idx < count-1: idx++, go to LOAD. Result is exactly 2 idle-high cycles between frames.
  - Else: seq_done=1, busy=0. Go to GAP if auto_on, otherwise IDLE.
- GAP:
  - Count GAP_CYCLES cycles with out=1, then go to IDLE.
  - The next sequence's start bit therefore begins GAP_CYCLES+3 cycles after the last stop bit ends (NEXT, GAP, IDLE, LOAD).
- start while busy or in GAP: ignored, not queued.
- auto_toggle:
  - Toggles auto_on on any cycle, in any state.
  - Clearing auto_on mid-sequence lets the current sequence finish, then returns to IDLE.
  - Clearing during GAP aborts the gap and goes to IDLE.
  - Setting it in IDLE starts a sequence on the following cycle.
- start and auto_toggle in the same IDLE cycle: sequence starts and auto_on toggles.
- word_idx = idx register; it holds its last value in IDLE/GAP until the next LOAD.
- Bit counter: $clog2(BIT_CYCLES) bits, compared to BIT_CYCLES-1, no free-running wrap.

Optional Feature:
- Macro: WORDGEN_PARITY_EN.
- When defined: an even-parity bit (XOR of the data bits) is inserted between the last data bit and the stop bit. Frame = (WORD_W+3)*BIT_CYCLES cycles; all other timing is unchanged.
- When undefined: no parity bit, and no parity logic is synthesised.

Decomposition:
- Shared package wordgen_pkg:
  - FSM state enum.
  - Line-level constants: IDLE_LVL=1, START_LVL=0, STOP_LVL=1.
  - Frame-length function of WORD_W plus the parity option.
- Sub-module serial_tx (params WORD_W, BIT_CYCLES):
  - Inputs: load pulse plus data.
  - Outputs: out and a last-stop-cycle flag.
  - Owns the bit and data counters and the parity.

Test Plan (WORD_W=8, N_WORDS=4, BIT_CYCLES=4, GAP_CYCLES=10):
- Reset mid-frame: rst high during a data bit -> next cycle out=1, busy=0, auto_on=0; a later start produces a clean 40-cycle frame.
- words={8'h44,8'h33,8'h22,8'h11}, count=2, start pulse -> start bit 2 cycles later; frame 0x11 bits 1,0,0,0,1,0,0,0 each 4 cycles; exactly 2 idle cycles; frame 0x22; seq_done pulses once; busy low; then no further activity.
- count=0 -> all 4 words sent, word_idx goes 0..3. start pulsed mid-sequence -> ignored, still exactly 4 frames.
- auto_toggle in IDLE with count=1 -> frames repeat with the next start bit 13 cycles after each stop bit. auto_toggle mid-frame -> current sequence completes, then IDLE, auto_on=0.
- Change words during SEND -> remaining frames of that sequence use the latched values; the next sequence uses the new values.
- With WORDGEN_PARITY_EN, word 8'h07 -> parity bit 1, frame length 44 cycles. word 8'h03 -> parity bit 0.
